// File: rtl/zif_pin_router.sv
// zif_pin_router: SPI-loaded per-pin routing table between the programmer MCU
// lines and the ZIF socket. Words are streamed into a shadow table and copied
// to the active table in one clock edge by a commit word. All routing from the
// active table to the pads is combinational.
//
// SPI handshake: there is no valid/ready pair. A bit is accepted on a
// synchronised SCK rising edge while the (delayed) synchronised CS is low and
// the front end is armed. A word is complete when the 4-bit counter wraps from
// 15 to 0. The decoded word acts on that same CLK edge. CS high discards any
// partial word.
module zif_pin_router #(
  parameter int ZIF_PINS = 40,
  parameter int INS      = 8,
  parameter int LANES    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SCK,
  input  logic                MOSI,
  input  logic                CS,
  input  logic                WR,
  input  logic [INS-1:0]      MIC_IN,
  inout  wire  [LANES-1:0]    MIC_IO,
  inout  wire  [ZIF_PINS-1:0] ZIF,
  output logic                BSY,
  output logic                ERR,
  output logic                CFG_ACTIVE
);

  // Index widths for the pin and lane tables.
  localparam int PIDX = (ZIF_PINS > 1) ? $clog2(ZIF_PINS) : 1;
  localparam int LIDX = (LANES > 1) ? $clog2(LANES) : 1;

  // ---------------------------------------------------------------------------
  // SPI front end
  // ---------------------------------------------------------------------------
  logic       sck_s1, sck_s2, sck_prev;
  logic       cs_s1, cs_s2, cs_q;
  logic       mosi_s1, mosi_s2;
  logic [1:0] flush;
  logic       armed;
  logic [14:0] shift_q;
  logic [3:0]  bit_cnt;

  logic sck_rise;
  logic shift_en;
  logic word_done;

  // Two-flop synchronisers plus one extra CS stage so that CS lines up with
  // sck_prev: an SCK edge arriving with CS rising is still accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      cs_q     <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
    end else begin
      sck_s1   <= SCK;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      cs_s1    <= CS;
      cs_s2    <= cs_s1;
      cs_q     <= cs_s2;
      mosi_s1  <= MOSI;
      mosi_s2  <= mosi_s1;
    end
  end

  // After reset the synchronisers hold idle values that do not reflect the
  // pads; wait for them to flush and then for CS to be seen high before
  // accepting any bit, so a frame cut by reset cannot leak into the next one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flush <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (flush != 2'd3) flush <= flush + 2'd1;
      if (flush == 2'd3 && cs_q) armed <= 1'b1;
    end
  end

  assign sck_rise  = sck_s2 & ~sck_prev;
  assign shift_en  = sck_rise & ~cs_q & armed;
  assign word_done = shift_en & (bit_cnt == 4'd15);

  // Shift register and bit counter; CS high drops a partial word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q <= '0;
      bit_cnt <= 4'd0;
    end else if (cs_q) begin
      bit_cnt <= 4'd0;
    end else if (shift_en) begin
      shift_q <= {shift_q[13:0], mosi_s2};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Word decode. The full word is {shift_q, mosi_s2}; fields are taken
  // straight from those bits so the 16th bit is used on the edge it arrives.
  // ---------------------------------------------------------------------------
  logic [1:0] op;
  logic [5:0] addr;
  logic [1:0] f_mode;
  logic [3:0] f_src;
  logic       f_en;
  logic [5:0] f_pin;

  assign op     = shift_q[14:13];
  assign addr   = shift_q[12:7];
  assign f_en   = shift_q[5];
  assign f_mode = shift_q[4:3];
  assign f_src  = {shift_q[2:0], mosi_s2};
  assign f_pin  = {shift_q[4:0], mosi_s2};

  logic wr_pin, wr_lane, wr_bsy, do_commit, do_clear, set_err;
  logic entry_bad;

  // Classify the completed word into one table action or an error.
  always_comb begin
    wr_pin    = 1'b0;
    wr_lane   = 1'b0;
    wr_bsy    = 1'b0;
    do_commit = 1'b0;
    do_clear  = 1'b0;
    set_err   = 1'b0;
    entry_bad = f_en && (int'(f_pin) >= ZIF_PINS);
    if (word_done) begin
      case (op)
        2'd0: begin
          if (int'(addr) < ZIF_PINS) wr_pin  = 1'b1;
          else                       set_err = 1'b1;
        end
        2'd1: begin
          if (int'(addr) < LANES) begin
            if (entry_bad) set_err = 1'b1;
            else           wr_lane = 1'b1;
          end else if (addr == 6'd63) begin
            if (entry_bad) set_err = 1'b1;
            else           wr_bsy  = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
        2'd2:    do_commit = 1'b1;
        default: do_clear  = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and active tables
  // ---------------------------------------------------------------------------
  logic [1:0] sh_mode     [ZIF_PINS];
  logic [3:0] sh_src      [ZIF_PINS];
  logic       sh_lane_en  [LANES];
  logic [5:0] sh_lane_pin [LANES];
  logic       sh_bsy_en;
  logic [5:0] sh_bsy_pin;

  logic [1:0] act_mode     [ZIF_PINS];
  logic [3:0] act_src      [ZIF_PINS];
  logic       act_lane_en  [LANES];
  logic [5:0] act_lane_pin [LANES];
  logic       act_bsy_en;
  logic [5:0] act_bsy_pin;

  // Shadow table: single-entry writes or a full clear.
  always_ff @(posedge CLK) begin
    if (RST || do_clear) begin
      for (int i = 0; i < ZIF_PINS; i++) begin
        sh_mode[i] <= 2'd0;
        sh_src[i]  <= 4'd0;
      end
      for (int b = 0; b < LANES; b++) begin
        sh_lane_en[b]  <= 1'b0;
        sh_lane_pin[b] <= 6'd0;
      end
      sh_bsy_en  <= 1'b0;
      sh_bsy_pin <= 6'd0;
    end else begin
      if (wr_pin) begin
        sh_mode[addr[PIDX-1:0]] <= f_mode;
        sh_src[addr[PIDX-1:0]]  <= f_src;
      end
      if (wr_lane) begin
        sh_lane_en[addr[LIDX-1:0]]  <= f_en;
        sh_lane_pin[addr[LIDX-1:0]] <= f_pin;
      end
      if (wr_bsy) begin
        sh_bsy_en  <= f_en;
        sh_bsy_pin <= f_pin;
      end
    end
  end

  // Active table: whole-table copy on commit so old and new never mix.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ZIF_PINS; i++) begin
        act_mode[i] <= 2'd0;
        act_src[i]  <= 4'd0;
      end
      for (int b = 0; b < LANES; b++) begin
        act_lane_en[b]  <= 1'b0;
        act_lane_pin[b] <= 6'd0;
      end
      act_bsy_en  <= 1'b0;
      act_bsy_pin <= 6'd0;
    end else if (do_commit) begin
      act_mode     <= sh_mode;
      act_src      <= sh_src;
      act_lane_en  <= sh_lane_en;
      act_lane_pin <= sh_lane_pin;
      act_bsy_en   <= sh_bsy_en;
      act_bsy_pin  <= sh_bsy_pin;
    end
  end

  // Status flags: a commit clears ERR, any rejected word sets it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR        <= 1'b0;
      CFG_ACTIVE <= 1'b0;
    end else if (do_commit) begin
      ERR        <= 1'b0;
      CFG_ACTIVE <= 1'b1;
    end else if (set_err) begin
      ERR <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational routing
  // ---------------------------------------------------------------------------
  logic [15:0]         src_vec;
  logic [ZIF_PINS-1:0] pin_oe;
  logic [ZIF_PINS-1:0] pin_val;
  logic [LANES-1:0]    lane_oe;
  logic [LANES-1:0]    lane_val;

  // Source vector: MCU inputs, then lanes, then constant zero.
  always_comb begin
    src_vec = '0;
    src_vec[INS-1:0]         = MIC_IN;
    src_vec[INS+LANES-1:INS] = MIC_IO;
  end

  // Per-pin drive enable by mode, and the selected source value.
  always_comb begin
    pin_oe  = '0;
    pin_val = '0;
    for (int i = 0; i < ZIF_PINS; i++) begin
      case (act_mode[i])
        2'd0:    pin_oe[i] = 1'b0;
        2'd1:    pin_oe[i] = 1'b1;
        2'd2:    pin_oe[i] = WR;
        default: pin_oe[i] = ~WR;
      endcase
      pin_val[i] = src_vec[act_src[i]];
    end
  end

  // Lane readback: the chosen socket pin back onto the MCU lane.
  always_comb begin
    lane_oe  = '0;
    lane_val = '0;
    for (int b = 0; b < LANES; b++) begin
      lane_oe[b]  = WR & act_lane_en[b];
      lane_val[b] = ZIF[act_lane_pin[b][PIDX-1:0]];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ZIF_PINS; gi++) begin : g_pin
      assign ZIF[gi] = pin_oe[gi] ? pin_val[gi] : 1'bz;
    end
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign MIC_IO[gi] = lane_oe[gi] ? lane_val[gi] : 1'bz;
    end
  endgenerate

  assign BSY = act_bsy_en & ZIF[act_bsy_pin[PIDX-1:0]];

endmodule

// File: tb/tb_zif_pin_router.sv
// Directed bench for zif_pin_router: SPI words with hand-computed routing
// expectations, checked on the socket pins, MCU lanes, BSY and status flags.
module tb_zif_pin_router;

  localparam int ZP = 40;
  localparam int NI = 8;
  localparam int NL = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sck, mosi, cs, wr;
  logic [NI-1:0] mic_in;
  wire  [NL-1:0] mic_io;
  wire  [ZP-1:0] zif;
  logic          bsy, err, cfg_active;

  // bench-side pad drivers
  logic [NL-1:0] io_oe, io_val;
  logic [ZP-1:0] zif_oe, zif_val;
  logic [ZP-1:0] zif_hiz;
  logic [NL-1:0] io_hiz;

  genvar gi;
  generate
    for (gi = 0; gi < ZP; gi++) begin : g_zif
      assign zif[gi]     = zif_oe[gi] ? zif_val[gi] : 1'bz;
      assign zif_hiz[gi] = (zif[gi] === 1'bz);
    end
    for (gi = 0; gi < NL; gi++) begin : g_io
      assign mic_io[gi] = io_oe[gi] ? io_val[gi] : 1'bz;
      assign io_hiz[gi] = (mic_io[gi] === 1'bz);
    end
  endgenerate

  zif_pin_router #(.ZIF_PINS(ZP), .INS(NI), .LANES(NL)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SCK        (sck),
    .MOSI       (mosi),
    .CS         (cs),
    .WR         (wr),
    .MIC_IN     (mic_in),
    .MIC_IO     (mic_io),
    .ZIF        (zif),
    .BSY        (bsy),
    .ERR        (err),
    .CFG_ACTIVE (cfg_active)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pins neither driven by the bench nor hi-Z (i.e. driven by the DUT)
  function automatic int dut_pins();
    return $countones(~zif_hiz & ~zif_oe);
  endfunction

  function automatic int dut_lanes();
    return $countones(~io_hiz & ~io_oe);
  endfunction

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Shift the first n bits of w; returns right after the last SCK rise.
  task automatic spi_raw(input logic [15:0] w, input int n);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi = w[15-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      if (i != n - 1) begin
        repeat (4) @(negedge clk);
        sck = 1'b0;
      end
    end
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    spi_raw(w, 16);
    spi_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b1; wr = 1'b0;
    mic_in = '0; io_oe = '0; io_val = '0; zif_oe = '0; zif_val = '0;

    // reset state with WR = 0 and WR = 1
    do_reset();
    #1;
    check("rst_pins_wr0", dut_pins(), 0);
    check("rst_lanes_wr0", dut_lanes(), 0);
    check("rst_bsy", bsy, 0);
    check("rst_err", err, 0);
    check("rst_cfg", cfg_active, 0);
    wr = 1'b1; #1;
    check("rst_pins_wr1", dut_pins(), 0);
    check("rst_lanes_wr1", dut_lanes(), 0);
    wr = 1'b0;

    // pin 14 <- MIC_IN[7], commit latency
    send_word(16'h0E17);
    #1;
    check("p14_shadow_only", zif_hiz[14], 1);
    check("cfg_before_commit", cfg_active, 0);
    mic_in[7] = 1'b1;
    spi_raw(16'h8000, 16);
    @(posedge clk); @(posedge clk); #1;
    check("commit_lat2_cfg", cfg_active, 0);
    check("commit_lat2_p14", zif_hiz[14], 1);
    @(posedge clk); #1;
    check("commit_lat3_cfg", cfg_active, 1);
    check("p14_follow_hi", zif[14], 1);
    mic_in[7] = 1'b0; #1;
    check("p14_follow_lo", zif[14], 0);
    spi_end();

    // pin 21 mode 3 from lane 0, lane 0 reads pin 21
    send_word(16'h1538);
    send_word(16'h4055);
    send_word(16'h8000);
    io_oe[0] = 1'b1; io_val[0] = 1'b1; #1;
    check("p21_wr0_hi", zif[21], 1);
    io_val[0] = 1'b0; #1;
    check("p21_wr0_lo", zif[21], 0);
    io_oe[0] = 1'b0;
    wr = 1'b1; #1;
    check("p21_wr1_hiz", zif_hiz[21], 1);
    zif_oe[21] = 1'b1; zif_val[21] = 1'b1; #1;
    check("lane0_rb_hi", mic_io[0], 1);
    zif_val[21] = 1'b0; #1;
    check("lane0_rb_lo", mic_io[0], 0);
    zif_oe[21] = 1'b0;
    wr = 1'b0; #1;
    check("lane0_wr0_hiz", io_hiz[0], 1);

    // BSY from pin 12, everything else cleared
    send_word(16'hC000);
    send_word(16'h7F4C);
    send_word(16'h8000);
    zif_oe[12] = 1'b1; zif_val[12] = 1'b1; #1;
    check("bsy_hi", bsy, 1);
    check("bsy_others_hiz", dut_pins(), 0);
    check("bsy_lanes_hiz", dut_lanes(), 0);
    zif_val[12] = 1'b0; #1;
    check("bsy_lo", bsy, 0);
    zif_val[12] = 1'b1;

    // bad pin address, errors and commit clearing them
    send_word(16'h2D01);
    #1;
    check("err_pin45", err, 1);
    check("err_tables_kept", bsy, 1);
    send_word(16'h8000);
    #1;
    check("err_cleared", err, 0);
    check("bsy_after_recommit", bsy, 1);
    send_word(16'h4170);
    #1;
    check("err_lane_badpin", err, 1);
    send_word(16'h8000);
    send_word(16'h2710);
    #1;
    check("pin39_ok_no_err", err, 0);

    // partial word aborted by CS, then commit
    spi_raw(16'h0A11, 9);
    spi_end();
    send_word(16'h8000);
    mic_in[0] = 1'b1; #1;
    check("partial_p10_hiz", zif_hiz[10], 1);
    check("p39_follow", zif[39], 1);
    send_word(16'h0A11);
    send_word(16'h8000);
    mic_in[1] = 1'b1; #1;
    check("p10_follow_hi", zif[10], 1);
    mic_in[1] = 1'b0; #1;
    check("p10_follow_lo", zif[10], 0);

    // clear + commit returns everything to hi-Z
    zif_oe = '0;
    send_word(16'hC000);
    send_word(16'h8000);
    #1;
    check("clear_pins_hiz", dut_pins(), 0);
    check("clear_bsy", bsy, 0);
    check("clear_cfg_kept", cfg_active, 1);

    // reset mid-word, then a clean frame
    spi_raw(16'h0A11, 7);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_cfg", cfg_active, 0);
    check("midrst_err", err, 0);
    check("midrst_pins", dut_pins(), 0);
    spi_end();
    send_word(16'h0A11);
    send_word(16'h8000);
    mic_in[1] = 1'b1; #1;
    check("post_rst_p10", zif[10], 1);
    check("post_rst_cfg", cfg_active, 1);
    check("post_rst_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zif_pin_router.md
# zif_pin_router

Parametrised, SPI-configured pin router between the programmer MCU lines and the ZIF socket. Replaces fixed per-device mappings with a loadable per-pin table: the MCU streams 16-bit configuration words over SPI into a shadow table, then commits them atomically to the active table. The active table drives socket pin enables, source selection, bidirectional lane readback and the BSY return line. The block sits between the MCU header pins and the ZIF socket pads.

## Interface
- ZIF_PINS, 40, number of socket pins (max 64)
- INS, 8, MCU input-only lines routable to the socket
- LANES, 8, MCU bidirectional data lanes (INS+LANES ≤ 16)
- CLK  input  1  system clock; must be ≥ 4× SCK frequency
- RST  input  1  synchronous, active-high reset
- SCK  input  1  SPI clock, asynchronous to CLK, sampled on rising edge
- MOSI  input  1  SPI data, MSB first
- CS  input  1  SPI chip select, active low
- WR  input  1  direction: 1 = socket→MCU readback, 0 = MCU→socket
- MIC_IN  input  INS  MCU input-only lines
- MIC_IO  inout  LANES  MCU bidirectional lanes
- ZIF  inout  ZIF_PINS  socket pins
- BSY  output  1  selected socket pin returned to MCU
- ERR  output  1  sticky bad-address flag
- CFG_ACTIVE  output  1  high once any commit has occurred

## Operation
- SPI front end: SCK, MOSI and CS each pass through a 2-FF synchroniser. An SCK rising edge is detected from the synchronised stage and the previous stage. On each edge with CS low, MOSI shifts into a 16-bit register and a 4-bit counter increments.
- Counter wrap from 15 to 0 completes a word. Continuous streaming under one CS low is allowed. CS high clears the counter and discards any partial word.
- Word format: [15:14] op, [13:8] addr, [7:0] data.
- op 0, pin entry: if addr < ZIF_PINS, shadow_pin[addr] is written with mode = data[5:4] and src = data[3:0]. Otherwise ERR is set.
- op 1, lane entry: if addr < LANES, shadow_lane[addr] is written with en = data[6] and pin = data[5:0]. If addr == 63, shadow_bsy is written with the same en/pin fields. Any other addr sets ERR.
- A lane or BSY entry whose pin ≥ ZIF_PINS with en = 1 sets ERR and is not written.
- op 2, commit: active tables are loaded from the shadow tables, CFG_ACTIVE is set, and ERR is cleared.
- op 3, clear: all shadow entries are zeroed. Active tables are unchanged.
- Source index: src < INS selects MIC_IN[src]. INS ≤ src < INS+LANES selects MIC_IO[src−INS]. Larger values select constant 0.
- Pin drive enable, by mode:
  - 0: hi-Z.
  - 1: always driven.
  - 2: driven when WR = 1.
  - 3: driven when WR = 0.
- When enabled, a pin is driven with its selected source.
- Lane b: MIC_IO[b] is driven with ZIF[pin] when WR = 1 and en = 1, otherwise hi-Z.
- BSY = ZIF[bsy.pin] when bsy.en = 1, otherwise 0.
- Routing paths (source→ZIF, ZIF→MIC_IO, ZIF→BSY) are purely combinational from the registered active table.

## Timing
- Reset values: all shadow and active entries 0, so every ZIF pin is hi-Z, every MIC_IO is hi-Z, and BSY = 0. ERR = 0, CFG_ACTIVE = 0, shift counter = 0, synchronisers = idle (CS high).
- Word decode occurs exactly 3 CLK cycles after the 16th SCK rising edge at the pin: 2 synchroniser cycles plus the edge-detect cycle. Table write happens on that edge.
- Commit: the active table is updated on the same edge as decode. Pin behaviour changes combinationally from then on.
- All entries update atomically. No intermediate mix of old and new mapping is ever visible.
- WR changes affect enables combinationally, with zero cycles of latency.
- CS rising in the same CLK cycle as the 16th edge: the word completes and is decoded (edge is processed first).
- RST mid-frame: the partial word is discarded and both tables are cleared. Next frame starts from bit 0 after CS is seen high.
- ERR set and commit in the same word stream: ERR is set by the earlier bad word and cleared by the later commit.

## Test plan
- Reset with WR = 0 and WR = 1 -> all ZIF and MIC_IO read Z, BSY = 0, ERR = 0, CFG_ACTIVE = 0.
- Word 0x0E17 (pin 14, mode 1, src 7) -> ZIF[14] stays Z. Then word 0x8000 -> 3 CLK after the 16th SCK edge, ZIF[14] follows toggling MIC_IN[7] and CFG_ACTIVE = 1.
- Load pin 21 word 0x1538 (mode 3, src 8), lane 0 word 0x4055, commit -> with WR = 0, ZIF[21] = MIC_IO[0]. With WR = 1, ZIF[21] is Z and MIC_IO[0] follows ZIF[21] driven by the bench.
- BSY word 0x7F4C (pin 12), commit -> BSY tracks ZIF[12] while all other pins stay Z.
- Word 0x2D01 (pin 45) -> ERR = 1 and the tables are unchanged. Commit clears ERR. Then 9 bits of word 0x0A11 with CS raised early -> no table change. A following full word applies correctly.
- Clear word 0xC000 followed by commit -> all pins return to Z. Assert RST mid-word -> reset state, and the next complete word decodes correctly.
